fifo_wptr_gray_full: RTL and testbench
======================================

// Module: fifo_wptr_gray_full
// PURPOSE
//   Write-side pointer and full-flag generator for the async FIFO.
//   Binary write pointer -> registered Gray pointer (bin-to-Gray encoder).
//   Output crosses to the read domain, where it is decoded Gray-to-binary.
//   Also synchronizes the incoming read Gray pointer and produces a registered full flag.
//   Sits in the write clock domain, between the producer and the dual-port memory.
// PARAMETERS
//   ADDR_SIZE     4  memory address width; DEPTH = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
//   AFULL_THRESH  2  almost_full asserts when free slots <= AFULL_THRESH (only with ALMOST_FULL_EN).
// PORTS
//   clk            in   1            write-domain clock, rising edge.
//   rst            in   1            asynchronous, active-high reset.
//   wr_en          in   1            producer write request.
//   rptr_gray_in   in   ADDR_SIZE+1  read Gray pointer from the read domain (asynchronous).
//   mem_we         out  1            memory write strobe = wr_en & ~full (combinational).
//   waddr          out  ADDR_SIZE    memory write address = wbin[ADDR_SIZE-1:0].
//   wptr_gray      out  ADDR_SIZE+1  registered Gray write pointer, to the read-domain synchronizer.
//   full           out  1            FIFO full, registered.
//   overflow       out  1            1-cycle pulse: wr_en was sampled while full.
//   almost_full    out  1            only present with ALMOST_FULL_EN.
// BEHAVIOUR
//   - Reset (rst=1, async): wbin=0, wptr_gray=0, sync flops=0, full=0, overflow=0, almost_full=0.
//   - Release: outputs update on the first rising clk edge after rst falls.
//   - Sync: rptr_gray_in -> rq1 -> rq2. Two flops, no logic between them.
//   - Per edge:
//       wbin_next = wbin + (wr_en & ~full), modulo 2**(ADDR_SIZE+1).
//       wgray_next = (wbin_next >> 1) ^ wbin_next.
//       wbin <= wbin_next; wptr_gray <= wgray_next. Exactly one Gray bit changes per write.
//   - Full: full <= (wgray_next == {~rq2[ADDR_SIZE:ADDR_SIZE-1], rq2[ADDR_SIZE-2:0]}).
//       The write that fills the FIFO raises full on that same edge.
//       full clears 3 edges after rptr_gray_in changes (2 sync + 1 register).
//       full is pessimistic only. It never reports not-full while the FIFO is full.
//   - Write while full:
//       mem_we=0; wbin and wptr_gray hold.
//       overflow <= 1 for one cycle, otherwise 0.
//   - Wrap-around: wbin 2*DEPTH-1 -> 0; wptr_gray 10..0 -> 0. No special handling.
//   - rptr_gray_in changing on the same edge as a write:
//       The old rq2 is used for that edge's compare. The new value is used on later edges.
//   - Reset mid-operation: all state clears immediately; an in-flight wr_en is dropped.
// CONFIGURATION
//   ALMOST_FULL_EN defined:
//     rbin_s = Gray-to-binary of rq2 (XOR prefix from MSB).
//     used = (wbin_next - rbin_s) mod 2**(ADDR_SIZE+1).
//     almost_full <= (used >= DEPTH - AFULL_THRESH), registered, reset 0.
//   ALMOST_FULL_EN undefined:
//     No almost_full port, no Gray-to-binary decoder, no subtractor.
// TESTING (ADDR_SIZE=4, DEPTH=16)
//   1. Reset: rst=1 mid-cycle -> outputs 0 immediately. Release, wr_en=0 for 3 edges -> outputs stay 0.
//   2. Fill: rptr_gray_in=0, 16 writes.
//        wptr_gray = 00001,00011,00010,00110,...
//        After the 16th write: wptr_gray=11000, waddr=0, full=1 on that edge.
//   3. Write while full: 1 more write -> mem_we=0, wptr_gray stays 11000, overflow=1 for 1 cycle then 0.
//   4. Drain: while full, set rptr_gray_in=00001 -> full=0 after the 3rd edge, and 1 write is then accepted.
//   5. Wrap: 40 writes with rptr_gray_in tracking wptr_gray at 4-edge lag.
//        wptr_gray passes 10000 -> 00000; full never sets; Gray Hamming distance per write is 1.
//   6. ALMOST_FULL_EN, AFULL_THRESH=2, rptr=0:
//        14 writes -> almost_full=1 on the 14th edge; full=0.
//        Reset -> almost_full=0.

Source files
------------

// File: rtl/fifo_wptr_gray_full.sv
// fifo_wptr_gray_full: write-domain pointer and full-flag logic for an async FIFO.
// Keeps a binary write pointer and a registered Gray copy that is sent to the read
// domain. It also brings the read Gray pointer across with a two-flop synchronizer
// and derives a registered full flag and a one-cycle overflow pulse.
// Optional feature: define ALMOST_FULL_EN to add the almost_full output and the
// AFULL_THRESH parameter. This also adds a Gray-to-binary decoder and an occupancy
// subtractor.
module fifo_wptr_gray_full #(
    parameter int ADDR_SIZE = 4
`ifdef ALMOST_FULL_EN
    , parameter int AFULL_THRESH = 2
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE:0]   rptr_gray_in,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr_gray,
    output logic                 full,
    output logic                 overflow
`ifdef ALMOST_FULL_EN
    , output logic               almost_full
`endif
);

    logic [ADDR_SIZE:0] wbin;
    logic [ADDR_SIZE:0] wbin_next;
    logic [ADDR_SIZE:0] wgray_next;
    logic [ADDR_SIZE:0] rq1;
    logic [ADDR_SIZE:0] rq2;
    logic               full_next;
    logic               accept;

    // A write is taken only when the FIFO is not full. The registered full flag
    // is pessimistic, so gating on it can never overrun the memory.
    assign accept = wr_en & ~full;
    assign mem_we = accept;
    assign waddr  = wbin[ADDR_SIZE-1:0];

    // Next pointer state. Full means the next Gray write pointer equals the
    // synchronized read pointer with its top two bits inverted, which is exactly
    // one lap ahead.
    always_comb begin
        wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, accept};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        full_next  = (wgray_next == {~rq2[ADDR_SIZE:ADDR_SIZE-1], rq2[ADDR_SIZE-2:0]});
    end

    // Two-flop synchronizer for the read Gray pointer. Only one bit changes per
    // read, so a sample taken mid-transition yields either the old or the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rptr_gray_in;
            rq2 <= rq1;
        end
    end

    // Pointer, full and overflow registers. A write while full leaves the pointers unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin      <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            full      <= full_next;
            overflow  <= wr_en & full;
        end
    end

`ifdef ALMOST_FULL_EN
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] AF_LEVEL = (ADDR_SIZE+1)'(DEPTH - AFULL_THRESH);

    logic [ADDR_SIZE:0] rbin_s;
    logic [ADDR_SIZE:0] used;

    // Decode the synchronized read pointer to binary. Each bit is the XOR of
    // itself and all bits above it. Occupancy is then measured against the
    // post-write pointer.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            rbin_s[i] = ^(rq2 >> i);
        end
        used = wbin_next - rbin_s;
    end

    // The almost_full flag is registered so that it updates on the same edge as full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (used >= AF_LEVEL);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wptr_gray_full.sv
// Testbench for fifo_wptr_gray_full with ADDR_SIZE=4 (DEPTH=16).
// The stimulus process pushes one expected-output record per clock into a queue.
// The monitor pops that record at each falling edge and compares it with the DUT.
// Expected values come from an occupancy model (writes minus synchronized reads)
// and from a hand-written table of Gray codes.
module tb_fifo_wptr_gray_full;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] rptr_gray_in;
    logic       mem_we;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       full;
    logic       overflow;
`ifdef ALMOST_FULL_EN
    logic       almost_full;
`endif

    fifo_wptr_gray_full #(.ADDR_SIZE(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rptr_gray_in(rptr_gray_in),
        .mem_we(mem_we),
        .waddr(waddr),
        .wptr_gray(wptr_gray),
        .full(full),
        .overflow(overflow)
`ifdef ALMOST_FULL_EN
        , .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    // Gray code of 0..31, written out by hand.
    logic [4:0] GRAY [32] = '{
        5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04,
        5'h0C, 5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08,
        5'h18, 5'h19, 5'h1B, 5'h1A, 5'h1E, 5'h1F, 5'h1D, 5'h1C,
        5'h14, 5'h15, 5'h17, 5'h16, 5'h12, 5'h13, 5'h11, 5'h10};

    typedef struct {
        logic [4:0] gray;
        logic [3:0] waddr;
        logic       full;
        logic       ovf;
        logic       af;
        logic       mem_we;
        logic       wrote;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    logic [4:0] prev_gray = '0;

    // Model state: binary write count, flags, and the read index seen by the sync stages.
    int   m_wbin, rq1b, rq2b;
    logic m_full, m_ovf, m_af;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: compare one pending expectation per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("wptr_gray", {3'b0, wptr_gray}, {3'b0, mon_e.gray});
            chk("waddr", {4'b0, waddr}, {4'b0, mon_e.waddr});
            chk("full", {7'b0, full}, {7'b0, mon_e.full});
            chk("overflow", {7'b0, overflow}, {7'b0, mon_e.ovf});
            chk("mem_we", {7'b0, mem_we}, {7'b0, mon_e.mem_we});
`ifdef ALMOST_FULL_EN
            chk("almost_full", {7'b0, almost_full}, {7'b0, mon_e.af});
`endif
            if (mon_e.wrote)
                chk("gray_hamming", 8'($countones(wptr_gray ^ prev_gray)), 8'd1);
            prev_gray = wptr_gray;
        end
    end

    task automatic model_reset();
        m_wbin = 0; rq1b = 0; rq2b = 0;
        m_full = 1'b0; m_ovf = 1'b0; m_af = 1'b0;
    endtask

    // Drive the inputs for the next rising edge and queue the expected state after that edge.
    task automatic drive(input logic we, input int rd);
        exp_t e;
        int   nb, used;
        logic acc;
        wr_en        = we;
        rptr_gray_in = GRAY[rd & 31];
        acc    = we && !m_full;
        m_ovf  = we && m_full;
        nb     = (m_wbin + int'(acc)) & 31;
        used   = (nb - rq2b) & 31;
        m_full = (used == 16);
        m_af   = (used >= 14);
        rq2b   = rq1b;
        rq1b   = rd & 31;
        m_wbin = nb;
        e.gray   = GRAY[nb];
        e.waddr  = 4'(nb);
        e.full   = m_full;
        e.ovf    = m_ovf;
        e.af     = m_af;
        e.mem_we = we && !m_full;
        e.wrote  = acc;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic we, input int rd);
        @(negedge clk);
        #2;
        drive(we, rd);
    endtask

    // Assert reset in the middle of the high phase. The check at the following
    // falling edge precedes any rising edge, so only an asynchronous clear can make
    // the outputs read zero there. wr_en is left unchanged and must be dropped.
    task automatic do_reset(input int rd);
        exp_t e;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        e.gray = '0; e.waddr = '0; e.full = 1'b0; e.ovf = 1'b0; e.af = 1'b0;
        e.mem_we = wr_en; e.wrote = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        #2;
        rst = 1'b0;
        drive(1'b0, rd);
    endtask

    initial begin
        int hist[$];
        int rd;
        rst = 1'b1;
        wr_en = 1'b0;
        rptr_gray_in = '0;
        model_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        drive(1'b0, 0);

        // 1. A few writes, then a mid-cycle reset with wr_en still high, then three idle edges.
        repeat (3) cyc(1'b1, 0);
        do_reset(0);
        repeat (3) cyc(1'b0, 0);

        // 2. Fill the FIFO with 16 writes. full rises on the 16th edge, with wptr_gray=11000.
        repeat (16) cyc(1'b1, 0);

        // 3. One more write while full is blocked and pulses overflow for one cycle.
        cyc(1'b1, 0);
        cyc(1'b0, 0);

        // 4. One read becomes visible. full drops after the 3rd edge, one write is taken, then full again.
        repeat (3) cyc(1'b0, 1);
        cyc(1'b1, 1);
        cyc(1'b1, 1);
        cyc(1'b0, 1);

        // 5. Forty writes past the wrap point, with the read pointer lagging by 4 edges.
        do_reset(0);
        for (int i = 0; i < 40; i++) begin
            rd = (i >= 4) ? hist[i-4] : 0;
            cyc(1'b1, rd);
            hist.push_back(m_wbin);
        end

        // 6. Fourteen writes with no reads: almost_full on the 14th edge, full stays low.
        do_reset(0);
        repeat (14) cyc(1'b1, 0);
        cyc(1'b0, 0);
        do_reset(0);
        cyc(1'b0, 0);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
